therm_frame_counter: RTL and testbench

- Downstream consumer of the 7-input sorting-network sorter.
- Accepts one sorted 7-bit thermometer word per cycle and converts it to a 3-bit population count.
- Flags thermometer codes that are not monotone.
- Accumulates the counts over a fixed-length frame and presents the frame total through a valid/ready handshake.
- Two stages: a decode register (S1) and an accumulator, controlled by a 2-state FSM.

---
 rtl/therm_frame_counter.sv | 138 +++++++++++++
 tb/tb_therm_frame_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/therm_frame_counter.sv
// Decodes sorted 7-bit thermometer words into popcounts, flags non-monotone codes,
// and accumulates a per-frame total handed off through a valid/ready port.
module therm_frame_counter #(
    parameter int FRAME_LEN = 16,
    parameter int SUM_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       therm,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [SUM_W-1:0] sum,
    output logic             sum_err
);

    localparam int WCNT_W = $clog2(FRAME_LEN);

    generate
        if (FRAME_LEN < 2 || FRAME_LEN > 1024) begin : g_bad_len
            $error("therm_frame_counter: FRAME_LEN must be in 2..1024");
        end
        if (SUM_W < $clog2(7 * FRAME_LEN + 1)) begin : g_bad_sum_w
            $error("therm_frame_counter: SUM_W too narrow for 7*FRAME_LEN");
        end
    endgenerate

    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               s1_vld_q, s1_vld_d;
    logic [2:0]         s1_cnt_q, s1_cnt_d;
    logic               s1_ill_q, s1_ill_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic               err_acc_q, err_acc_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               sum_err_q, sum_err_d;
    logic               sum_valid_q, sum_valid_d;

    logic [2:0]         cnt3;
    logic               ill;
    logic               accept;
    logic               drain;

    // A legal code never has a 1 directly below a 0.
    always_comb begin
        cnt3 = 3'd0;
        for (int i = 0; i < 7; i++) begin
            cnt3 = cnt3 + 3'(therm[i]);
        end
        ill = |(therm[5:0] & ~therm[6:1]);
    end

    assign in_ready = !rst && (state_q == ACCUM || !s1_vld_q);
    assign accept   = in_valid && in_ready;
    assign drain    = s1_vld_q && (state_q == ACCUM);

    always_comb begin
        state_d     = state_q;
        s1_vld_d    = s1_vld_q;
        s1_cnt_d    = s1_cnt_q;
        s1_ill_d    = s1_ill_q;
        acc_d       = acc_q;
        err_acc_d   = err_acc_q;
        wcnt_d      = wcnt_q;
        sum_d       = sum_q;
        sum_err_d   = sum_err_q;
        sum_valid_d = sum_valid_q;

        if (accept) begin
            s1_vld_d = 1'b1;
            s1_cnt_d = cnt3;
            s1_ill_d = ill;
        end else if (drain) begin
            s1_vld_d = 1'b0;
        end

        case (state_q)
            ACCUM: begin
                if (drain) begin
                    if (wcnt_q == WCNT_W'(FRAME_LEN - 1)) begin
                        sum_d       = acc_q + SUM_W'(s1_cnt_q);
                        sum_err_d   = err_acc_q | s1_ill_q;
                        sum_valid_d = 1'b1;
                        acc_d       = '0;
                        err_acc_d   = 1'b0;
                        wcnt_d      = '0;
                        state_d     = DONE;
                    end else begin
                        acc_d     = acc_q + SUM_W'(s1_cnt_q);
                        err_acc_d = err_acc_q | s1_ill_q;
                        wcnt_d    = wcnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (sum_valid_q && sum_ready) begin
                    sum_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            s1_vld_q    <= 1'b0;
            s1_cnt_q    <= 3'd0;
            s1_ill_q    <= 1'b0;
            acc_q       <= '0;
            err_acc_q   <= 1'b0;
            wcnt_q      <= '0;
            sum_q       <= '0;
            sum_err_q   <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_vld_q    <= s1_vld_d;
            s1_cnt_q    <= s1_cnt_d;
            s1_ill_q    <= s1_ill_d;
            acc_q       <= acc_d;
            err_acc_q   <= err_acc_d;
            wcnt_q      <= wcnt_d;
            sum_q       <= sum_d;
            sum_err_q   <= sum_err_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum       = sum_q;
    assign sum_err   = sum_err_q;
    assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_therm_frame_counter.sv
// Bench for therm_frame_counter: frame-level scoreboard plus directed frames with hand totals.
module tb_therm_frame_counter;

    localparam int FL = 16;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [6:0]    therm = 7'd0;
    logic          sum_valid;
    logic          sum_ready = 1'b0;
    logic [SW-1:0] sum;
    logic          sum_err;

    always #5 clk = ~clk;

    therm_frame_counter #(.FRAME_LEN(FL), .SUM_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .therm(therm),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum(sum), .sum_err(sum_err)
    );

    typedef struct {int s; bit e; int first; int last;} res_t;

    int         n_pass = 0, n_tot = 0, cyc = 0, n_acc = 0;
    res_t       exp_q[$];
    res_t       obs_q[$];
    logic [6:0] src[$];
    int         in_pct = 100, rdy_pct = 100;
    bit         rdy_hold0 = 1'b0;
    bit         last_acc = 1'b0;
    int         m_sum = 0, m_cnt = 0, m_first = 0;
    bit         m_err = 1'b0;
    bit         e_sv, e_sr, e_rst;
    int         p_sum = 0;
    bit         p_err = 1'b0;

    function automatic int pop7(input logic [6:0] w);
        int n = 0;
        for (int i = 0; i < 7; i++) if (w[i]) n++;
        return n;
    endfunction

    // Legal words are k ones packed at the top of the 7-bit field.
    function automatic bit is_legal(input logic [6:0] w);
        for (int k = 0; k <= 7; k++)
            if (int'(w) == (((1 << k) - 1) << (7 - k))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] code(input int k);
        return 7'(((1 << k) - 1) << (7 - k));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Frame model: sees every accepted word in order and closes a frame every FL words.
    always @(posedge clk) begin
        cyc++;
        e_sv = sum_valid; e_sr = sum_ready; e_rst = rst;
        last_acc = !rst && in_valid && in_ready;
        if (rst) begin
            m_sum = 0; m_err = 1'b0; m_cnt = 0;
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            if (m_cnt == 0) m_first = cyc;
            m_sum += pop7(therm);
            m_err |= !is_legal(therm);
            m_cnt++;
            n_acc++;
            void'(src.pop_front());
            if (m_cnt == FL) begin
                exp_q.push_back('{m_sum, m_err, m_first, cyc});
                m_sum = 0; m_err = 1'b0; m_cnt = 0;
            end
        end
    end

    // Upstream holds a word until it is taken; downstream readiness is throttled.
    always @(negedge clk) begin
        in_valid = (src.size() > 0) &&
                   ((in_valid && !last_acc) || ($urandom_range(99) < in_pct));
        if (src.size() > 0) therm = src[0];
        sum_ready = !rdy_hold0 && ($urandom_range(99) < rdy_pct);
    end

    always begin
        res_t r;
        @(posedge clk);
        #2;
        if (e_rst) begin
            chk("rst_valid", sum_valid, 0);
            chk("rst_sum", sum, 0);
            chk("rst_err", sum_err, 0);
            if (rst) chk("rst_in_ready", in_ready, 0);
        end else if (e_sv && !e_sr) begin
            chk("hold_valid", sum_valid, 1);
            chk("hold_sum", sum, p_sum);
            chk("hold_err", sum_err, p_err);
        end else if (sum_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", sum_valid, 0);
            end else begin
                r = exp_q.pop_front();
                chk("sum", sum, r.s);
                chk("sum_err", sum_err, r.e);
                chk("latency", cyc, r.last + 1);
                obs_q.push_back('{int'(sum), sum_err, r.first, cyc});
            end
        end
        p_sum = sum; p_err = sum_err;
    end

    task automatic wait_res(input string name, output res_t r);
        int t = 0;
        while (obs_q.size() == 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (obs_q.size() == 0) begin
            chk({name, "_timeout"}, obs_q.size(), 1);
            r = '{-1, 1'b0, 0, 0};
        end else begin
            r = obs_q.pop_front();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   n0, got, t;

        rst = 1'b1;
        for (int i = 0; i < FL; i++) src.push_back(7'h7f);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Back-to-back full frame: first accept edge 1, result after edge 17.
        wait_res("t1", r);
        chk("t1_sum", r.s, 112);
        chk("t1_err", r.e, 0);
        chk("t1_latency", r.last - r.first, 16);

        // Counts 0..7 twice, two identical frames.
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < FL; i++) src.push_back(code(i % 8));
        wait_res("t2a", r);
        chk("t2a_sum", r.s, 56);
        chk("t2a_err", r.e, 0);
        wait_res("t2b", r);
        chk("t2b_sum", r.s, 56);
        chk("t2b_err", r.e, 0);

        // One illegal word among 1110000 words, then a clean frame.
        for (int i = 0; i < 7; i++) src.push_back(code(3));
        src.push_back(7'b0100000);
        for (int i = 0; i < 8; i++) src.push_back(code(3));
        for (int i = 0; i < FL; i++) src.push_back(7'h7f);
        wait_res("t3a", r);
        chk("t3a_sum", r.s, 46);
        chk("t3a_err", r.e, 1);
        wait_res("t3b", r);
        chk("t3b_sum", r.s, 112);
        chk("t3b_err", r.e, 0);

        // Downstream stall: only one word of the next frame gets buffered.
        rdy_hold0 = 1'b1;
        n0 = n_acc;
        for (int i = 0; i < FL; i++) src.push_back(code(2));
        for (int i = 0; i < FL; i++) src.push_back(code(5));
        wait_res("t4a", r);
        chk("t4a_sum", r.s, 32);
        repeat (10) @(negedge clk);
        chk("t4_accepted", n_acc - n0, FL + 1);
        chk("t4_in_ready", in_ready, 0);
        rdy_hold0 = 1'b0;
        wait_res("t4b", r);
        chk("t4b_sum", r.s, 80);
        chk("t4b_err", r.e, 0);

        // Reset after word 9 of a frame discards it.
        for (int i = 0; i < 9; i++) src.push_back(7'h7f);
        t = 0;
        while (src.size() > 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("t5_drain", src.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_no_result", obs_q.size(), 0);
        for (int i = 0; i < FL; i++) src.push_back(code(1));
        wait_res("t5", r);
        chk("t5_sum", r.s, 16);
        chk("t5_err", r.e, 0);

        // Throttled random traffic; per-frame checks come from the scoreboard.
        in_pct = 60;
        rdy_pct = 50;
        for (int f = 0; f < 200; f++)
            for (int i = 0; i < FL; i++)
                src.push_back(($urandom_range(9) < 7) ? code($urandom_range(7))
                                                      : 7'($urandom_range(127)));
        got = 0;
        for (int f = 0; f < 200; f++) begin
            wait_res("t6", r);
            if (r.s >= 0) got++;
        end
        chk("t6_frames", got, 200);
        chk("t6_pending", exp_q.size(), 0);
        chk("t6_src_left", src.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
